// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalisation pipeline: default sizes used by the
// CDF memory, divider and LUT, plus the divider-sequencer state encoding.
package hist_eq_pkg;

  localparam int unsigned DEF_NBINS       = 256;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_DIV_TIMEOUT = 64;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRd    = 3'd1,
    StLatch = 3'd2,
    StIssue = 3'd3,
    StWait  = 3'd4,
    StWrite = 3'd5,
    StDone  = 3'd6
  } div_ctrl_state_e;

endpackage

// File: rtl/hist_eq_div_ctrl_if.sv
// Control, CDF-read, divider and LUT-write signals of the divider sequencer.
// master = sequencer side, slave = surrounding memories / divider / controller.
interface hist_eq_div_ctrl_if #(
  parameter int unsigned ADDR_W = hist_eq_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = hist_eq_pkg::DEF_DATA_W
);

  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              cdf_rd_en;
  logic [ADDR_W-1:0] cdf_rd_addr;
  logic [DATA_W-1:0] cdf_rd_data;
  logic              div_start;
  logic [DATA_W-1:0] div_cdf;
  logic [DATA_W-1:0] div_g;
  logic              div_ready;
  logic              lut_wr_en;
  logic [ADDR_W-1:0] lut_wr_addr;
  logic [DATA_W-1:0] lut_wr_data;

  modport master (
    input  start, cdf_rd_data, div_g, div_ready,
    output busy, done, err, cdf_rd_en, cdf_rd_addr, div_start, div_cdf,
           lut_wr_en, lut_wr_addr, lut_wr_data
  );

  modport slave (
    output start, cdf_rd_data, div_g, div_ready,
    input  busy, done, err, cdf_rd_en, cdf_rd_addr, div_start, div_cdf,
           lut_wr_en, lut_wr_addr, lut_wr_data
  );

endinterface

// File: rtl/hist_eq_div_watchdog.sv
// WAIT-cycle counter for the divider sequencer; only built with HIST_EQ_DIV_CTRL_TIMEOUT_EN.
// expired is high on the LIMIT-th consecutive enabled cycle since the last clear.
`ifdef HIST_EQ_DIV_CTRL_TIMEOUT_EN
module hist_eq_div_watchdog #(
  parameter int unsigned LIMIT = hist_eq_pkg::DEF_DIV_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == CntW'(LIMIT - 1));

endmodule
`endif

// File: rtl/hist_eq_div_ctrl.sv
// Divider sequencer: walks every CDF bin through the divider into the equalisation LUT.
// Define HIST_EQ_DIV_CTRL_TIMEOUT_EN to abort a run (err, done) when the divider stalls.
module hist_eq_div_ctrl
  import hist_eq_pkg::*;
#(
  parameter int unsigned NBINS       = DEF_NBINS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DIV_TIMEOUT = DEF_DIV_TIMEOUT
) (
  input logic                clk,
  input logic                reset,
  hist_eq_div_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NBINS - 1);

  div_ctrl_state_e   state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              cdf_rd_en_q;
  logic [ADDR_W-1:0] cdf_rd_addr_q;
  logic              div_start_q;
  logic [DATA_W-1:0] div_cdf_q;
  logic              lut_wr_en_q;
  logic [ADDR_W-1:0] lut_wr_addr_q;
  logic [DATA_W-1:0] lut_wr_data_q;
  logic              wd_expired;

`ifdef HIST_EQ_DIV_CTRL_TIMEOUT_EN
  hist_eq_div_watchdog #(
    .LIMIT(DIV_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == StIssue),
    .enable (state_q == StWait),
    .expired(wd_expired)
  );
`else
  logic unused_div_timeout;
  assign unused_div_timeout = |DIV_TIMEOUT;
  assign wd_expired = 1'b0;
`endif

  // Outputs are registered: each strobe is loaded on the transition into its state so it
  // is high for exactly the one cycle spent there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cdf_rd_en_q   <= 1'b0;
      cdf_rd_addr_q <= '0;
      div_start_q   <= 1'b0;
      div_cdf_q     <= '0;
      lut_wr_en_q   <= 1'b0;
      lut_wr_addr_q <= '0;
      lut_wr_data_q <= '0;
    end else begin
      cdf_rd_en_q <= 1'b0;
      div_start_q <= 1'b0;
      lut_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          idx_q <= '0;
          if (bus.start) begin
            state_q       <= StRd;
            busy_q        <= 1'b1;
            err_q         <= 1'b0;
            cdf_rd_en_q   <= 1'b1;
            cdf_rd_addr_q <= '0;
          end
        end
        StRd: begin
          state_q <= StLatch;
        end
        StLatch: begin
          div_cdf_q   <= bus.cdf_rd_data;
          div_start_q <= 1'b1;
          state_q     <= StIssue;
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          // A ready on the expiry cycle still counts as a result.
          if (bus.div_ready) begin
            lut_wr_data_q <= bus.div_g;
            lut_wr_en_q   <= 1'b1;
            lut_wr_addr_q <= idx_q;
            state_q       <= StWrite;
          end else if (wd_expired) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StWrite: begin
          // Terminal check precedes the increment, so idx never wraps.
          if (idx_q == LastIdx) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q         <= idx_q + 1'b1;
            cdf_rd_en_q   <= 1'b1;
            cdf_rd_addr_q <= idx_q + 1'b1;
            state_q       <= StRd;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.cdf_rd_en   = cdf_rd_en_q;
  assign bus.cdf_rd_addr = cdf_rd_addr_q;
  assign bus.div_start   = div_start_q;
  assign bus.div_cdf     = div_cdf_q;
  assign bus.lut_wr_en   = lut_wr_en_q;
  assign bus.lut_wr_addr = lut_wr_addr_q;
  assign bus.lut_wr_data = lut_wr_data_q;

endmodule

// File: tb/tb_hist_eq_div_ctrl.sv
// Scoreboard bench for hist_eq_div_ctrl: CDF memory and divider models drive the DUT,
// expected LUT writes are queued per run and checked by an independent monitor.
module tb_hist_eq_div_ctrl;

  localparam int unsigned NB     = 256;
  localparam int unsigned AW     = 8;
  localparam int unsigned DW     = 8;
  localparam int unsigned DIV_TO = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hist_eq_div_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  hist_eq_div_ctrl #(
    .NBINS      (NB),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .DIV_TIMEOUT(DIV_TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] cdf_mem [NB];
  logic [DW-1:0] g_off = '0;
  int  w_fixed = 0;
  int  stuck_bin = -1;
  bit  spurious = 1'b0;
  wr_t exp_q[$];
  bit  exp_err = 1'b0;
  int  exp_issues = 0;
  int  ds_count = 0;
  int  w_total = 0;
  int  issue_idx = 0;
  int  done_count = 0;
  int  start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // CDF memory (1-cycle read latency) and divider (g = cdf + g_off after W WAIT cycles).
  initial begin : models
    int cnt;
    bit pend;
    logic [AW-1:0] paddr;
    logic [DW-1:0] op;
    logic [DW-1:0] want_op;
    cnt = 0;
    pend = 1'b0;
    paddr = '0;
    op = '0;
    bus.cdf_rd_data = '0;
    bus.div_ready = 1'b0;
    bus.div_g = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        pend = 1'b0;
        bus.div_ready = 1'b0;
        bus.cdf_rd_data = '0;
        continue;
      end
      bus.cdf_rd_data = pend ? cdf_mem[paddr] : DW'($urandom);
      pend = bus.cdf_rd_en;
      paddr = bus.cdf_rd_addr;
      bus.div_ready = 1'b0;
      bus.div_g = DW'($urandom);
      if (bus.div_start) begin
        op = bus.div_cdf;
        want_op = (issue_idx < NB) ? cdf_mem[issue_idx] : '0;
        check("div_operand", op, want_op);
        if (issue_idx == stuck_bin) begin
          cnt = -1;
          w_total += 3 + DIV_TO;
        end else begin
          cnt = (w_fixed > 0) ? w_fixed : int'($urandom_range(1, 6));
          w_total += 4 + cnt;
        end
        issue_idx++;
        ds_count++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.div_ready = 1'b1;
          bus.div_g = op + g_off;
        end
      end
      // Bogus results in every non-WAIT cycle, ISSUE included.
      if (spurious && bus.busy && !bus.div_ready && (bus.div_start || cnt == 0)) begin
        bus.div_ready = 1'b1;
        bus.div_g = 8'hAA;
      end
    end
  end

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (bus.lut_wr_en) begin
        check("lut_write_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("lut_wr_addr", bus.lut_wr_addr, e.addr);
          check("lut_wr_data", bus.lut_wr_data, e.data);
        end
      end
      if (bus.done) begin
        done_count++;
        check("run_length", cyc - start_cyc, w_total + 1);
        check("writes_outstanding", exp_q.size(), 0);
        check("err_at_done", bus.err, exp_err);
        check("div_start_count", ds_count, exp_issues);
      end
    end
  end

  task automatic run(input int wfix, input bit spur, input int stuck, input bit ramp,
                     input bit inject, input int abort_bin);
    int n;
    int k;
    int base;
    int len;
    bit seen;
    bit aborted;
    logic [DW-1:0] v;
    wr_t e;
    g_off = ramp ? 8'd1 : DW'($urandom);
    for (int i = 0; i < NB; i++) cdf_mem[i] = ramp ? DW'(i) : DW'($urandom);
    w_fixed = wfix;
    spurious = spur;
    stuck_bin = stuck;
    n = (stuck >= 0) ? stuck : NB;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      v = cdf_mem[i] + g_off;
      e.addr = i;
      e.data = int'(v);
      exp_q.push_back(e);
    end
    exp_err = (stuck >= 0);
    exp_issues = (stuck >= 0) ? stuck + 1 : NB;
    w_total = 0;
    issue_idx = 0;
    ds_count = 0;
    base = done_count;
    start_cyc = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", bus.busy, 1);
    check("err_cleared", bus.err, 0);
    seen = 1'b0;
    aborted = 1'b0;
    len = 0;
    k = 1;
    while (k < 20000 && !seen && !aborted) begin
      if (bus.done) begin
        seen = 1'b1;
        len = cyc - start_cyc;
        if (inject) bus.start = 1'b1;
      end else if (abort_bin >= 0 && bus.cdf_rd_en && bus.cdf_rd_addr == AW'(abort_bin)) begin
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_strobes", {bus.cdf_rd_en, bus.div_start, bus.lut_wr_en}, 0);
        check("abort_regs", {bus.div_cdf, bus.lut_wr_data}, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("abort_no_done", done_count, base);
        aborted = 1'b1;
      end else begin
        if (inject && k == 100) begin
          bus.start = 1'b1;
          check("busy_mid_run", bus.busy, 1);
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    check("run_ended", int'(seen || aborted), 1);
    if (seen) begin
      if (wfix == 3 && stuck < 0) check("run_length_w3", len, NB * 7 + 1);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_fall", bus.busy, 0);
      check("done_single", bus.done, 0);
      repeat (8) @(negedge clk);
      check("no_restart", bus.busy, 0);
      check("done_count", done_count, base + 1);
    end
  endtask

  initial begin : stim
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("reset_idle", {bus.busy, bus.done, bus.err, bus.cdf_rd_en, bus.div_start,
                           bus.lut_wr_en, bus.cdf_rd_addr, bus.lut_wr_addr, bus.div_cdf,
                           bus.lut_wr_data}, 0);
    end
    run(3, 1'b0, -1, 1'b1, 1'b1, -1);
    run(0, 1'b1, -1, 1'b0, 1'b0, -1);
    run(0, 1'b0, -1, 1'b0, 1'b0, 40);
    repeat (3) @(negedge clk);
    run(0, 1'b0, -1, 1'b0, 1'b0, -1);
`ifdef HIST_EQ_DIV_CTRL_TIMEOUT_EN
    run(0, 1'b0, 5, 1'b0, 1'b0, -1);
    check("err_sticky", bus.err, 1);
    run(2, 1'b0, -1, 1'b0, 1'b0, -1);
    check("err_after_clean_run", bus.err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hist_eq_div_ctrl.md
# hist_eq_div_ctrl

Sequencer for the histogram-equalisation divider stage. On a start pulse it walks all CDF bins, reads each bin from the CDF memory, issues it to the divider, waits for the divider's ready, and writes the resulting grey level into the equalisation LUT. It sits between the CDF accumulator memory and the LUT consumed by the pixel-remap stage, and owns the divider exclusively while busy.

## Interface
- NBINS, 256: number of CDF bins processed per run
- ADDR_W, 8: bin address width, clog2(NBINS)
- DATA_W, 8: CDF and grey-level width
- DIV_TIMEOUT, 64: maximum WAIT cycles per bin (used only with timeout enabled)

- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run (normal or aborted)
- err  out  1  divider timeout occurred; sticky until next accepted start
- cdf_rd_en  out  1  CDF memory read strobe
- cdf_rd_addr  out  ADDR_W  CDF read address (current bin)
- cdf_rd_data  in  DATA_W  CDF data, valid the cycle after cdf_rd_en
- div_start  out  1  one-cycle pulse launching a division
- div_cdf  out  DATA_W  registered operand to divider, stable from ISSUE until next LATCH
- div_g  in  DATA_W  divider result, valid while div_ready high
- div_ready  in  1  divider result valid
- lut_wr_en  out  1  LUT write strobe
- lut_wr_addr  out  ADDR_W  LUT write address (current bin)
- lut_wr_data  out  DATA_W  registered grey level

## Operation
- States: IDLE, RD, LATCH, ISSUE, WAIT, WRITE, DONE.
- IDLE: idx=0. start=1 -> RD, err cleared. start=0 -> stay.
- RD: cdf_rd_en=1, cdf_rd_addr=idx -> LATCH.
- LATCH: div_cdf <= cdf_rd_data -> ISSUE.
- ISSUE: div_start=1 -> WAIT; wait counter cleared.
- WAIT: div_ready=1 -> lut_wr_data <= div_g, go WRITE; else stay, counter++.
- WRITE: lut_wr_en=1, lut_wr_addr=idx. idx==NBINS-1 -> DONE; else idx++ -> RD.
- DONE: done=1 for one cycle -> IDLE.
- Strobe outputs (cdf_rd_en, div_start, lut_wr_en, done) are state-decoded, high exactly one cycle per visit.
- div_ready outside WAIT (including the ISSUE cycle) is ignored; div_g is sampled only on div_ready in WAIT.
- start outside IDLE ignored, including in the DONE cycle.
- idx is ADDR_W wide; never wraps, since the terminal check precedes the increment.
- Reset values: all outputs 0, state IDLE, idx 0, div_cdf 0, lut_wr_data 0, err 0.
- Reset mid-run: returns to IDLE next cycle, no done pulse, LUT left partially written; the divider shares the same reset.

## Timing
- Per bin: 4 fixed cycles (RD, LATCH, ISSUE, WRITE) plus W WAIT cycles, W>=1 being the cycle count until div_ready is seen.
- Run length from start-sampled edge to done-high cycle: NBINS*(4+W)+1 cycles for constant W.
- busy rises the cycle after start is sampled and falls the cycle after done.
- cdf_rd_data read latency fixed at 1 cycle; no backpressure on the LUT write port.

## Configuration
- HIST_EQ_DIV_CTRL_TIMEOUT_EN defined: WAIT counter active; when DIV_TIMEOUT cycles elapse in WAIT without div_ready, err<=1 and go to DONE. Remaining bins are not written and done still pulses.
- Undefined: no counter; WAIT holds indefinitely; err tied 0; DIV_TIMEOUT unused.

## Structure
- Shared package hist_eq_pkg: state encoding constants, NBINS/ADDR_W/DATA_W defaults shared with the divider and LUT.
- One sub-module: hist_eq_div_watchdog (WAIT cycle counter with clear/enable/expire), instantiated only under HIST_EQ_DIV_CTRL_TIMEOUT_EN.

## Test plan
- Reset held 2 cycles then released, no start -> all outputs 0, busy 0 indefinitely.
- Full run, divider model ready 3 cycles after div_start (W=3), g=cdf+1, CDF[i]=i -> LUT[i]=i+1 for i=0..254, LUT[255]=0 (8-bit wrap from model); done exactly 1793 cycles after start sampled; exactly 256 div_start and 256 lut_wr_en pulses.
- start pulsed again at cycle 100 of a run, and on the DONE cycle -> ignored; a single done, no restart.
- Spurious div_ready during RD/LATCH/ISSUE of bin 7 with div_g=8'hAA -> LUT[7] holds the value presented in WAIT, never 8'hAA.
- Reset asserted mid-run at bin 40 -> IDLE next cycle, no done, busy 0; new start begins at bin 0.
- With TIMEOUT_EN, DIV_TIMEOUT=16, divider never ready on bin 5 -> LUT 0..4 written only, err=1 and done after 16 WAIT cycles; next start clears err.
